// File: rtl/mem_io_controller.sv
// mem_io_controller: wait-stated RAM plus memory-mapped input latches, output registers and input-status word behind a req/ack handshake (Clock/clear; req/we/addr/wdata -> rdata/ack/err/busy; inport_data/inport_strobe; outport_data/outport_valid)
module mem_io_controller #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2,
  parameter int NUM_IN      = 2,
  parameter int NUM_OUT     = 2,
  parameter int IO_BASE     = (1 << ADDR_WIDTH) - 8
) (
  input  logic                          Clock,
  input  logic                          clear,
  input  logic                          req,
  input  logic                          we,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          ack,
  output logic                          err,
  output logic                          busy,
  input  logic [NUM_IN*DATA_WIDTH-1:0]  inport_data,
  input  logic [NUM_IN-1:0]             inport_strobe,
  output logic [NUM_OUT*DATA_WIDTH-1:0] outport_data,
  output logic [NUM_OUT-1:0]            outport_valid
);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] io_base = ADDR_WIDTH'(IO_BASE);
  localparam logic [3:0] ws = 4'(WAIT_STATES);
  if (NUM_IN + NUM_OUT > 7) begin : g_bad_map
    $error("mem_io_controller: NUM_IN + NUM_OUT must not exceed 7");
  end
  logic [1:0] state;
  logic [3:0] cnt;
  logic [ADDR_WIDTH-1:0] r_addr, c_addr, off;
  logic r_we, c_we, c_io, commit, hit, ro, c_err;
  logic [DATA_WIDTH-1:0] r_wdata, c_wdata, io_rd, mem_rd;
  logic [DATA_WIDTH-1:0] mem [IO_BASE];
  logic [DATA_WIDTH-1:0] in_lat [NUM_IN];
  logic [NUM_IN-1:0] status;
  assign ack     = state == S_RESP;
  assign busy    = state != S_IDLE;
  assign c_addr  = state == S_IDLE ? addr : r_addr;
  assign c_we    = state == S_IDLE ? we : r_we;
  assign c_wdata = state == S_IDLE ? wdata : r_wdata;
  assign c_io    = c_addr >= io_base;
  assign off     = c_addr - io_base;
  assign mem_rd  = mem[c_addr];
  assign commit  = (state == S_IDLE && req && (c_io || WAIT_STATES == 0)) ||
                   (state == S_WAIT && cnt == 4'd1);
  always_comb begin
    io_rd = '0;
    hit   = 1'b0;
    ro    = 1'b0;
    for (int k = 0; k < NUM_IN; k++)
      if (off == ADDR_WIDTH'(k)) begin
        io_rd = in_lat[k];
        hit   = 1'b1;
        ro    = 1'b1;
      end
    for (int j = 0; j < NUM_OUT; j++)
      if (off == ADDR_WIDTH'(NUM_IN + j)) begin
        io_rd = outport_data[j*DATA_WIDTH +: DATA_WIDTH];
        hit   = 1'b1;
      end
    if (off == ADDR_WIDTH'(7)) begin
      io_rd = DATA_WIDTH'(status);
      hit   = 1'b1;
      ro    = 1'b1;
    end
    c_err = c_io && (!hit || (ro && c_we));
  end
  always_ff @(posedge Clock) begin
    if (!clear) begin
      state         <= S_IDLE;
      cnt           <= '0;
      r_addr        <= '0;
      r_we          <= 1'b0;
      r_wdata       <= '0;
      rdata         <= '0;
      err           <= 1'b0;
      outport_data  <= '0;
      outport_valid <= '0;
      status        <= '0;
      for (int k = 0; k < NUM_IN; k++) in_lat[k] <= '0;
    end else begin
      state <= state == S_IDLE ? (req ? (c_io || WAIT_STATES == 0 ? S_RESP : S_WAIT) : S_IDLE)
             : state == S_WAIT ? (cnt == 4'd1 ? S_RESP : S_WAIT) : S_IDLE;
      cnt <= state == S_IDLE ? ws : cnt - 4'd1;
      if (state == S_IDLE && req) begin
        r_addr  <= addr;
        r_we    <= we;
        r_wdata <= wdata;
      end
      outport_valid <= '0;
      if (commit) begin
        err   <= c_err;
        rdata <= c_we || c_err ? '0 : (c_io ? io_rd : mem_rd);
        for (int j = 0; j < NUM_OUT; j++)
          if (c_io && c_we && off == ADDR_WIDTH'(NUM_IN + j)) begin
            outport_data[j*DATA_WIDTH +: DATA_WIDTH] <= c_wdata;
            outport_valid[j] <= 1'b1;
          end
      end
      for (int k = 0; k < NUM_IN; k++)
        if (inport_strobe[k]) begin
          in_lat[k] <= inport_data[k*DATA_WIDTH +: DATA_WIDTH];
          status[k] <= 1'b1;
        end else if (commit && c_io && !c_we && off == ADDR_WIDTH'(k)) begin
          status[k] <= 1'b0;
        end
    end
  end
  always_ff @(posedge Clock)
    if (clear && commit && !c_io && c_we) mem[c_addr] <= c_wdata;
endmodule

// File: tb/tb_mem_io_controller.sv
// tb_mem_io_controller: directed self-checking bench for mem_io_controller (WAIT_STATES=2 and WAIT_STATES=0 builds)
module tb_mem_io_controller;
  logic clk = 1'b0, clear = 1'b0;
  logic req = 1'b0, we = 1'b0;
  logic [8:0] addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic ack, err, busy;
  logic [63:0] inport_data = '0;
  logic [1:0] inport_strobe = '0;
  logic [63:0] outport_data;
  logic [1:0] outport_valid;
  logic req0 = 1'b0, we0 = 1'b0;
  logic [8:0] addr0 = '0;
  logic [31:0] wdata0 = '0, rdata0;
  logic ack0, err0, busy0;
  logic [63:0] outport_data0;
  logic [1:0] outport_valid0;
  int n_checks = 0, n_fail = 0;
  logic ack_after;
  logic [31:0] rd;
  logic er;
  int lat;
  logic [1:0] ov;
  mem_io_controller u_dut (
    .Clock(clk), .clear(clear), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .busy(busy),
    .inport_data(inport_data), .inport_strobe(inport_strobe),
    .outport_data(outport_data), .outport_valid(outport_valid)
  );
  mem_io_controller #(.WAIT_STATES(0)) u_dut0 (
    .Clock(clk), .clear(clear), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0),
    .inport_data(inport_data), .inport_strobe(inport_strobe),
    .outport_data(outport_data0), .outport_valid(outport_valid0)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic access(input logic w, input logic [8:0] a, input logic [31:0] d);
    we = w;
    addr = a;
    wdata = d;
    req = 1'b1;
    step();
    req = 1'b0;
    inport_strobe = '0;
    lat = 1;
    while (!ack && lat < 20) begin
      step();
      lat++;
    end
    if (!ack) check("ack_timeout", {63'd0, ack}, 64'd1);
    rd = rdata;
    er = err;
    ov = outport_valid;
    step();
    ack_after = ack;
  endtask
  task automatic strobe(input int ch, input logic [31:0] d);
    inport_data[ch*32 +: 32] = d;
    inport_strobe[ch] = 1'b1;
    step();
    inport_strobe = '0;
  endtask
  initial begin
    repeat (3) step();
    check("rst_rdata", rdata, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_outdata", outport_data, 0);
    check("rst_outvalid", outport_valid, 0);
    clear = 1'b1;
    step();
    access(1'b1, 9'h020, 32'hDEADBEEF);
    access(1'b1, 9'h010, 32'hDEADBEEF);
    check("ram_wr_lat", lat, 3);
    check("ram_wr_err", er, 0);
    check("ram_wr_rdata", rd, 0);
    access(1'b0, 9'h010, 32'h0);
    check("ram_rd_data", rd, 32'hDEADBEEF);
    check("ram_rd_err", er, 0);
    check("ram_rd_lat", lat, 3);
    check("ram_rd_ackw", ack_after, 0);
    access(1'b1, 9'h1FB, 32'h55);
    check("out_wr_lat", lat, 1);
    check("out_wr_valid", ov, 2'b10);
    check("out_wr_ch1", outport_data[63:32], 32'h55);
    check("out_wr_ch0", outport_data[31:0], 0);
    check("out_valid_pulse", outport_valid, 0);
    access(1'b0, 9'h1FB, 32'h0);
    check("out_rd", rd, 32'h55);
    strobe(0, 32'h1234);
    access(1'b0, 9'h1FF, 32'h0);
    check("status_set", rd, 32'h1);
    access(1'b0, 9'h1F8, 32'h0);
    check("in0_rd", rd, 32'h1234);
    access(1'b0, 9'h1FF, 32'h0);
    check("status_clr", rd, 32'h0);
    inport_data[31:0] = 32'hAAAA;
    inport_strobe[0] = 1'b1;
    access(1'b0, 9'h1F8, 32'h0);
    check("same_edge_old", rd, 32'h1234);
    access(1'b0, 9'h1FF, 32'h0);
    check("same_edge_status", rd, 32'h1);
    access(1'b0, 9'h1F8, 32'h0);
    check("same_edge_new", rd, 32'hAAAA);
    strobe(1, 32'h77);
    access(1'b1, 9'h1F8, 32'h999);
    check("err_wr_in", er, 1);
    check("err_wr_in_rd", rd, 0);
    access(1'b0, 9'h1FE, 32'h0);
    check("err_unmapped", er, 1);
    check("err_unmapped_rd", rd, 0);
    access(1'b1, 9'h1FF, 32'h3);
    check("err_wr_status", er, 1);
    access(1'b0, 9'h1FF, 32'h0);
    check("err_status_kept", rd, 32'h2);
    check("ok_err_clear", er, 0);
    access(1'b0, 9'h1F9, 32'h0);
    check("err_in1_kept", rd, 32'h77);
    access(1'b0, 9'h1F8, 32'h0);
    check("err_in0_kept", rd, 32'hAAAA);
    we = 1'b1;
    addr = 9'h020;
    wdata = 32'hFFFFFFFF;
    req = 1'b1;
    step();
    req = 1'b0;
    check("midwait_busy", busy, 1);
    clear = 1'b0;
    step();
    check("midrst_rdata", rdata, 0);
    check("midrst_ack", ack, 0);
    check("midrst_err", err, 0);
    check("midrst_busy", busy, 0);
    check("midrst_outdata", outport_data, 0);
    check("midrst_outvalid", outport_valid, 0);
    step();
    check("midrst_ack2", ack, 0);
    clear = 1'b1;
    step();
    check("midrst_ack3", ack, 0);
    access(1'b0, 9'h020, 32'h0);
    check("midrst_ram_kept", rd, 32'hDEADBEEF);
    we0 = 1'b1;
    addr0 = 9'h000;
    wdata0 = 32'hA0;
    req0 = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ws0_ack_%0d", i), ack0, (i % 2) == 0);
      check($sformatf("ws0_busy_%0d", i), busy0, (i % 2) == 0);
      if (ack0) begin
        addr0 = addr0 ^ 9'h001;
        wdata0 = 32'hA0 + 32'(addr0);
      end
      if (i < 7) step();
    end
    req0 = 1'b0;
    step();
    we0 = 1'b0;
    addr0 = 9'h001;
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    check("ws0_rd_ack", ack0, 1);
    check("ws0_rd_data", rdata0, 32'hA1);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
